// File: rtl/sfp_pkg.sv
// sfp_pkg: shared types and helpers for the sfp_multi accumulate-and-activate
// stage.
//   - sfp_state_e : two-state group FSM (ACC accumulating, DONE result held)
//   - sat_max/sat_min : signed saturation bounds for a w-bit lane
//   - sat_add     : saturating signed add, clamped to a w-bit lane (w <= 62)
//   - lane_lsb    : bit offset of lane k inside a packed vector of w-bit lanes
package sfp_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } sfp_state_e;

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

    // Operands are already sign-extended w-bit values, so the 64-bit sum
    // cannot wrap before it is clamped.
    function automatic longint sat_add(input longint a, input longint b,
                                       input int unsigned w);
        longint sum;
        sum = a + b;
        if (sum > sat_max(w)) return sat_max(w);
        if (sum < sat_min(w)) return sat_min(w);
        return sum;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned k,
                                             input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/sfp_lane.sv
// sfp_lane: one channel of sfp_multi -- accumulator register, saturating
// adder and output activation.
// Configuration macro: SFP_MULTI_RELU_EN (defined -> ReLU, else pass-through).
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   clear_i  in  drop the running sum (applied before any add this cycle)
//   en_i     in  add psum_i into the accumulator this cycle
//   psum_i   in  signed partial sum for this lane
//   act_o    out activated accumulator value
module sfp_lane #(
    parameter int unsigned psum_bw = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      en_i,
    input  logic signed [psum_bw-1:0] psum_i,
    output logic        [psum_bw-1:0] act_o
);
    import sfp_pkg::*;

    logic signed [psum_bw-1:0] acc_q;
    logic signed [psum_bw-1:0] acc_d;
    logic signed [psum_bw-1:0] base;

    // A clear together with a beat starts the new group from that beat.
    always_comb begin
        // NOTE: every variable gets a value on entry so no path can infer a latch.
        base  = clear_i ? '0 : acc_q;
        acc_d = base;
        if (en_i) begin
            acc_d = psum_bw'(sat_add(longint'(base), longint'(psum_i), psum_bw));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef SFP_MULTI_RELU_EN
    // Negative and zero both map to 0, so the sign bit alone decides.
    assign act_o = acc_q[psum_bw-1] ? '0 : acc_q;
`else
    assign act_o = acc_q;
`endif

endmodule

// File: rtl/sfp_multi.sv
// sfp_multi: col-lane accumulate-and-activate stage between the PE-array
// column outputs and the output SRAM write port. Each lane sums signed
// partial sums with saturation; one activated vector is presented per group
// over valid/ready while the input is back-pressured.
// Configuration macro: SFP_MULTI_RELU_EN (defined -> ReLU per lane).
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   in       in  packed signed partial sums, lane k at [k*psum_bw +: psum_bw]
//   i_valid  in  in carries a beat
//   i_last   in  final beat of the group (qualified by i_valid)
//   i_clear  in  discard the running group (ignored while a result is held)
//   i_ready  out block accepts a beat (ACC state)
//   out      out packed activated results, valid while o_valid
//   o_valid  out completed group is held (DONE state)
//   o_ready  in  consumer takes out this cycle
//   o_beats  out beats in the current/completed group, saturating
module sfp_multi #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned cnt_bw  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [psum_bw*col-1:0]   in,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic                     i_clear,
    output logic                     i_ready,
    output logic [psum_bw*col-1:0]   out,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [cnt_bw-1:0]        o_beats
);
    import sfp_pkg::*;

    sfp_state_e        state_q;
    sfp_state_e        state_d;
    logic [cnt_bw-1:0] beats_q;
    logic [cnt_bw-1:0] beats_d;
    logic [cnt_bw-1:0] beats_base;
    logic              accept;
    logic              lane_clear;

    // Handshake outputs are pure functions of state.
    assign i_ready = (state_q == ACC);
    assign o_valid = (state_q == DONE);
    assign accept  = i_ready && i_valid;

    // In ACC the clear comes from i_clear; in DONE the completing handshake
    // empties the lanes so the next group starts from zero.
    assign lane_clear = i_ready ? i_clear : o_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && i_last) state_d = DONE;
            DONE:    if (o_ready)          state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        beats_base = lane_clear ? '0 : beats_q;
        beats_d    = beats_base;
        if (accept && (beats_base != '1)) begin
            beats_d = beats_base + cnt_bw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACC;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
        end
    end

    assign o_beats = beats_q;

    for (genvar k = 0; k < col; k++) begin : g_lane
        localparam int unsigned Lsb = lane_lsb(k, psum_bw);
        sfp_lane #(
            .psum_bw (psum_bw)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear_i (lane_clear),
            .en_i    (accept),
            .psum_i  (in[Lsb +: psum_bw]),
            .act_o   (out[Lsb +: psum_bw])
        );
    end

endmodule

// File: tb/tb_sfp_multi.sv
// tb_sfp_multi: self-checking bench for sfp_multi. A group-level integer
// model (per-lane clamped sums, beat count, result-pending flag) predicts
// outputs; directed scenarios also compare against hand-computed constants.
`timescale 1ns/1ps
module tb_sfp_multi;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int CNT_BW  = 8;
    localparam int SMAX    = 32767;
    localparam int SMIN    = -32768;
    localparam int BMAX    = 255;

    logic                   clk     = 1'b0;
    logic                   reset   = 1'b1;
    logic [PSUM_BW*COL-1:0] in      = '0;
    logic                   i_valid = 1'b0;
    logic                   i_last  = 1'b0;
    logic                   i_clear = 1'b0;
    logic                   o_ready = 1'b0;
    logic                   i_ready;
    logic                   o_valid;
    logic [PSUM_BW*COL-1:0] out;
    logic [CNT_BW-1:0]      o_beats;

    int vectors     = 0;
    int miscompares = 0;

    int m_acc[COL];
    int m_beats = 0;
    bit m_done  = 1'b0;

    sfp_multi #(
        .psum_bw (PSUM_BW),
        .col     (COL),
        .cnt_bw  (CNT_BW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_clear (i_clear),
        .i_ready (i_ready),
        .out     (out),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_beats (o_beats)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    function automatic int act(input int x);
`ifdef SFP_MULTI_RELU_EN
        return (x > 0) ? x : 0;
`else
        return x;
`endif
    endfunction

    function automatic int lane_of(input logic [PSUM_BW*COL-1:0] v, input int k);
        return int'($signed(v[k*PSUM_BW +: PSUM_BW]));
    endfunction

    function automatic logic [PSUM_BW*COL-1:0] splat(input int x);
        logic [PSUM_BW*COL-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(x);
        return r;
    endfunction

    function automatic logic [PSUM_BW*COL-1:0] exp_out();
        logic [PSUM_BW*COL-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(act(m_acc[k]));
        return r;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < COL; k++) m_acc[k] = 0;
        m_beats = 0;
    endfunction

    // Advance the model with the inputs present at the coming edge, then
    // step one clock and settle just past the edge.
    task automatic cycle();
        if (reset) begin
            model_clear();
            m_done = 1'b0;
        end else if (!m_done) begin
            if (i_clear) model_clear();
            if (i_valid) begin
                for (int k = 0; k < COL; k++) m_acc[k] = clamp(m_acc[k] + lane_of(in, k));
                if (m_beats < BMAX) m_beats++;
                if (i_last) m_done = 1'b1;
            end
        end else if (o_ready) begin
            model_clear();
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [PSUM_BW*COL-1:0] v, input bit last, input bit clr);
        in      = v;
        i_valid = 1'b1;
        i_last  = last;
        i_clear = clr;
        cycle();
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
        vectors++; if (o_beats !== '0) begin miscompares++; $display("FAIL reset_o_beats: got %0d want 0", o_beats); end
        vectors++; if (out !== '0) begin miscompares++; $display("FAIL reset_out: got %h want 0", out); end
    endtask

    task automatic test_basic();
        o_ready = 1'b1;
        beat(splat(5), 1'b0, 1'b0);
        beat(splat(7), 1'b0, 1'b0);
        vectors++; if (i_ready !== 1'b1 || o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_mid_state: got ready=%b valid=%b want 1/0", i_ready, o_valid); end
        beat(splat(-2), 1'b1, 1'b0);
        vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL basic_o_valid: got %b want 1", o_valid); end
        vectors++; if (i_ready !== 1'b0) begin miscompares++; $display("FAIL basic_i_ready: got %b want 0", i_ready); end
        vectors++; if (out !== splat(10)) begin miscompares++; $display("FAIL basic_out: got %h want %h", out, splat(10)); end
        vectors++; if (o_beats !== CNT_BW'(3)) begin miscompares++; $display("FAIL basic_o_beats: got %0d want 3", o_beats); end
        cycle();
        vectors++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin miscompares++; $display("FAIL basic_return: got valid=%b ready=%b want 0/1", o_valid, i_ready); end
        vectors++; if (o_beats !== '0) begin miscompares++; $display("FAIL basic_beats_cleared: got %0d want 0", o_beats); end
    endtask

    task automatic test_relu();
        logic [PSUM_BW*COL-1:0] v;
        int want0;
`ifdef SFP_MULTI_RELU_EN
        want0 = 0;
`else
        want0 = -10;
`endif
        o_ready = 1'b1;
        v = '0; v[0 +: PSUM_BW] = PSUM_BW'(-4); v[PSUM_BW +: PSUM_BW] = PSUM_BW'(3);
        beat(v, 1'b0, 1'b0);
        v = '0; v[0 +: PSUM_BW] = PSUM_BW'(-6); v[PSUM_BW +: PSUM_BW] = PSUM_BW'(4);
        beat(v, 1'b1, 1'b0);
        vectors++; if (lane_of(out, 0) !== want0) begin miscompares++; $display("FAIL relu_lane0: got %0d want %0d", lane_of(out, 0), want0); end
        vectors++; if (lane_of(out, 1) !== 7) begin miscompares++; $display("FAIL relu_lane1: got %0d want 7", lane_of(out, 1)); end
        cycle();
    endtask

    task automatic test_saturation();
        logic [PSUM_BW*COL-1:0] v;
        int want1;
`ifdef SFP_MULTI_RELU_EN
        want1 = 0;
`else
        want1 = -32768;
`endif
        o_ready = 1'b1;
        v = '0; v[0 +: PSUM_BW] = PSUM_BW'(30000); v[PSUM_BW +: PSUM_BW] = PSUM_BW'(-30000);
        beat(v, 1'b0, 1'b0);
        beat(v, 1'b0, 1'b0);
        v = '0; v[0 +: PSUM_BW] = PSUM_BW'(-100);
        beat(v, 1'b1, 1'b0);
        vectors++; if (lane_of(out, 0) !== 32667) begin miscompares++; $display("FAIL sat_lane0: got %0d want 32667", lane_of(out, 0)); end
        vectors++; if (lane_of(out, 1) !== want1) begin miscompares++; $display("FAIL sat_lane1: got %0d want %0d", lane_of(out, 1), want1); end
        vectors++; if (out !== exp_out()) begin miscompares++; $display("FAIL sat_model: got %h want %h", out, exp_out()); end
        cycle();
    endtask

    task automatic test_backpressure();
        o_ready = 1'b0;
        beat(splat(4), 1'b1, 1'b0);
        in      = splat(9);
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            vectors++; if (i_ready !== 1'b0 || o_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_%0d: got ready=%b valid=%b want 0/1", c, i_ready, o_valid); end
            vectors++; if (out !== splat(4) || o_beats !== CNT_BW'(1)) begin miscompares++; $display("FAIL bp_stable_%0d: got %h/%0d want %h/1", c, out, o_beats, splat(4)); end
        end
        o_ready = 1'b1;
        cycle();
        vectors++; if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_beats !== '0) begin miscompares++; $display("FAIL bp_release: got ready=%b valid=%b beats=%0d want 1/0/0", i_ready, o_valid, o_beats); end
        i_last = 1'b1;
        cycle();
        i_valid = 1'b0;
        i_last  = 1'b0;
        vectors++; if (out !== splat(9) || o_beats !== CNT_BW'(1)) begin miscompares++; $display("FAIL bp_fresh: got %h/%0d want %h/1", out, o_beats, splat(9)); end
        cycle();
    endtask

    task automatic test_clear();
        o_ready = 1'b1;
        beat(splat(50), 1'b0, 1'b0);
        beat(splat(50), 1'b0, 1'b0);
        beat(splat(1), 1'b0, 1'b1);
        o_ready = 1'b0;
        beat(splat(2), 1'b1, 1'b0);
        vectors++; if (out !== splat(3) || o_beats !== CNT_BW'(2)) begin miscompares++; $display("FAIL clear_beat: got %h/%0d want %h/2", out, o_beats, splat(3)); end
        i_clear = 1'b1;
        cycle();
        i_clear = 1'b0;
        vectors++; if (o_valid !== 1'b1 || out !== splat(3) || o_beats !== CNT_BW'(2)) begin miscompares++; $display("FAIL clear_in_done: got valid=%b %h/%0d want 1 %h/2", o_valid, out, o_beats, splat(3)); end
        o_ready = 1'b1;
        cycle();
        beat(splat(100), 1'b0, 1'b0);
        beat(splat(-7), 1'b1, 1'b1);
        vectors++; if (o_valid !== 1'b1 || out !== splat(act(-7)) || o_beats !== CNT_BW'(1)) begin miscompares++; $display("FAIL clear_last: got valid=%b %h/%0d want 1 %h/1", o_valid, out, o_beats, splat(act(-7))); end
        cycle();
    endtask

    task automatic test_reset_mid();
        o_ready = 1'b1;
        beat(splat(20), 1'b0, 1'b0);
        beat(splat(20), 1'b0, 1'b0);
        reset = 1'b1;
        beat(splat(20), 1'b1, 1'b0);
        reset = 1'b0;
        vectors++; if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_beats !== '0) begin miscompares++; $display("FAIL reset_mid_group: got valid=%b ready=%b beats=%0d want 0/1/0", o_valid, i_ready, o_beats); end
        o_ready = 1'b0;
        beat(splat(6), 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        vectors++; if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_beats !== '0) begin miscompares++; $display("FAIL reset_in_done: got valid=%b ready=%b beats=%0d want 0/1/0", o_valid, i_ready, o_beats); end
        o_ready = 1'b1;
        beat(splat(11), 1'b1, 1'b0);
        vectors++; if (out !== splat(11) || o_beats !== CNT_BW'(1)) begin miscompares++; $display("FAIL reset_then_11: got %h/%0d want %h/1", out, o_beats, splat(11)); end
        cycle();
    endtask

    task automatic test_beats_saturate();
        o_ready = 1'b1;
        for (int b = 0; b < 270; b++) beat(splat(1), 1'b0, 1'b0);
        vectors++; if (o_beats !== CNT_BW'(BMAX) || i_ready !== 1'b1) begin miscompares++; $display("FAIL beats_sat: got %0d ready=%b want 255/1", o_beats, i_ready); end
        beat(splat(1), 1'b1, 1'b0);
        vectors++; if (o_valid !== 1'b1 || o_beats !== CNT_BW'(BMAX) || out !== splat(271)) begin miscompares++; $display("FAIL beats_sat_done: got valid=%b %0d %h want 1 255 %h", o_valid, o_beats, out, splat(271)); end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < COL; k++) begin
                if ($urandom_range(0, 3) == 0)
                    in[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(int'($urandom_range(0, 200)) - 100);
                else
                    in[k*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom_range(0, 65535));
            end
            i_valid = ($urandom_range(0, 9) < 7);
            i_last  = ($urandom_range(0, 4) == 0);
            i_clear = ($urandom_range(0, 19) == 0);
            o_ready = ($urandom_range(0, 1) == 1);
            reset   = ($urandom_range(0, 199) == 0);
            cycle();
            vectors++; if (i_ready !== !m_done) begin miscompares++; $display("FAIL rand_i_ready[%0d]: got %b want %b", n, i_ready, !m_done); end
            vectors++; if (o_valid !== m_done) begin miscompares++; $display("FAIL rand_o_valid[%0d]: got %b want %b", n, o_valid, m_done); end
            vectors++; if (o_beats !== CNT_BW'(m_beats)) begin miscompares++; $display("FAIL rand_o_beats[%0d]: got %0d want %0d", n, o_beats, m_beats); end
            if (m_done) begin
                vectors++; if (out !== exp_out()) begin miscompares++; $display("FAIL rand_out[%0d]: got %h want %h", n, out, exp_out()); end
            end
        end
        reset   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_clear = 1'b0;
        o_ready = 1'b1;
        cycle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_beats_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sfp_multi.md
# sfp_multi

Multi-channel accumulate-and-activate stage for the array output path. It sits between the PE-array column outputs and the output SRAM write port. Each of `col` lanes sums a stream of signed partial sums, with saturation. It presents one activated result vector per accumulation group using a valid/ready handshake, and back-pressures the input while that result is pending.

## Interface
- `psum_bw`, 16: bit width of each partial sum, accumulator and output lane.
- `col`, 8: number of independent channels (lanes).
- `cnt_bw`, 8: width of the beat counter.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in`  in  psum_bw*col: packed signed partial sums; lane k is `in[k*psum_bw +: psum_bw]`.
- `i_valid`  in  1: `in` carries a beat.
- `i_last`  in  1: the current beat is the final one of the group; qualified by `i_valid`.
- `i_clear`  in  1: discard the running group.
- `i_ready`  out  1: block can accept a beat.
- `out`  out  psum_bw*col: packed activated results; lane order matches `in`.
- `o_valid`  out  1: `out` holds a completed group.
- `o_ready`  in  1: consumer takes `out` this cycle.
- `o_beats`  out  cnt_bw: number of beats in the current or completed group; saturates at 2^cnt_bw-1.

## Operation
- Two states: ACC and DONE.
- **ACC:** `i_ready`=1 and `o_valid`=0. Each accepted beat (`i_valid`&&`i_ready`) adds lane k of `in` into acc[k] with signed saturation to [-2^(psum_bw-1), 2^(psum_bw-1)-1], and increments `o_beats`.
- **ACC → DONE:** when an accepted beat has `i_last`=1; that beat is still included in the sum.
- **DONE:** `i_ready`=0 and `o_valid`=1. acc and `o_beats` are frozen, and `i_valid` is ignored.
- **DONE → ACC:** on `o_ready`=1. In that same edge, acc and `o_beats` clear to 0.
- `out` lane k = act(acc[k]). It is driven combinationally from acc and is meaningful only while `o_valid`=1.
- **`i_clear` in ACC:** acc and `o_beats` go to 0.
  - If the same cycle also has an accepted beat, acc = saturate(in) and `o_beats`=1; a new group starts with that beat.
  - If that beat also has `i_last`, go to DONE with that single-beat sum.
- **`i_clear` in DONE:** ignored; the result is never dropped.
- **Overflow:** lanes saturate independently; there is no wrap-around and no overflow flag.
- **Reset:** state=ACC, all acc=0, `o_beats`=0, `o_valid`=0, `i_ready`=1, `out`=0. Reset mid-group or while in DONE discards everything and takes priority over every other input.

## Timing
- Accumulate: one beat per cycle in ACC; no bubbles between groups except the DONE cycle(s).
- Latency: `o_valid` rises in the cycle after the `i_last` beat is accepted.
- Minimum occupancy of DONE is 1 cycle. If `o_ready` is already high, the next beat can be accepted in the following cycle.
- Group throughput: N beats produce one result every N+1 cycles when `o_ready` is held high.
- `i_ready` depends only on state, never on `i_valid`.
- `o_valid` depends only on state, never on `o_ready`.
- `o_valid` must not drop until the handshake completes.

## Configuration
- Macro: `SFP_MULTI_RELU_EN`.
- **Defined:** act(x) = x if x > 0, else 0 (ReLU per lane).
- **Undefined:** act(x) = x; the saturated signed sum passes through unchanged.
- Accumulation, saturation and the handshake are identical in both builds.

## Structure
- **Package `sfp_pkg`:**
  - state enum {ACC, DONE};
  - functions for the saturation bounds and saturating signed add, parametrised on width;
  - the lane-packing helper.
- **Sub-module `sfp_lane`:** one accumulator register, saturating adder and activation, instantiated `col` times by generate.
- **Top level:** owns the FSM, `o_beats` counter, handshake and the broadcast clear/enable to the lanes.

## Test plan
- **Basic group:** 3 beats, all lanes = 5, 7, -2, `i_last` on the third, `o_ready`=1 → `o_valid` the next cycle, every lane = 10, `o_beats`=3, back in ACC one cycle later.
- **ReLU:** lane 0 receives -4 then -6 (last) → lane 0 = 0 with `SFP_MULTI_RELU_EN`, -10 without; lane 1 receiving 3 then 4 gives 7 in both builds.
- **Saturation:** `psum_bw`=16, lane 0 receives 30000, 30000, -100 (last) → 32667. Lane 1 receives -30000 twice (last) → -32768, which becomes 0 under ReLU.
- **Back-pressure:** hold `o_ready`=0 for 5 cycles after `o_valid` while `i_valid`=1 with value 9 → `i_ready`=0 throughout, `out` stable. Raise `o_ready` → the next accepted beat starts a fresh group, so `out` is 9 once `i_last` arrives.
- **Clear with beat:** after 2 beats of 50, assert `i_clear` together with a beat of 1, then a `i_last` beat of 2 → result 3, `o_beats`=2.
- **Reset:** assert `reset` mid-group and separately while in DONE → next cycle `o_valid`=0, `i_ready`=1, `o_beats`=0; a following single-beat group of 11 yields 11.
